// File: rtl/msix_vector_ctrl_if.sv
// Bundles the two buses of the MSI-X vector controller:
// the table access port used by the BAR register decoder and the
// irq_valid/irq_ready request channel consumed by irq_proc.
interface msix_vector_ctrl_if #(
   parameter int NUM_VEC = 4,
   parameter int VEC_W   = $clog2(NUM_VEC),
   parameter int TBL_AW  = VEC_W + 2
) ();
   logic              tbl_we;
   logic [TBL_AW-1:0] tbl_addr;
   logic [31:0]       tbl_wdata;
   logic              tbl_re;
   logic [31:0]       tbl_rdata;
   logic              tbl_rvalid;

   logic              irq_valid;
   logic [3:0]        irq_func;
   logic [63:0]       irq_addr;
   logic [31:0]       irq_data;
   logic              irq_ready;

   // Interrupt source side: serves table accesses, issues requests.
   modport master (
      input  tbl_we, tbl_addr, tbl_wdata, tbl_re, irq_ready,
      output tbl_rdata, tbl_rvalid, irq_valid, irq_func, irq_addr, irq_data
   );

   // Decoder / irq_proc side: drives table accesses, accepts requests.
   modport slave (
      output tbl_we, tbl_addr, tbl_wdata, tbl_re, irq_ready,
      input  tbl_rdata, tbl_rvalid, irq_valid, irq_func, irq_addr, irq_data
   );
endinterface

// File: rtl/msix_vector_ctrl.sv
// MSI-X style interrupt source: vector table (address, data, mask),
// pending-bit array, round-robin arbitration over pending unmasked
// vectors and a single outstanding request on the irq handshake.
module msix_vector_ctrl #(
   parameter int         NUM_VEC  = 4,
   parameter int         VEC_W    = $clog2(NUM_VEC),
   parameter int         TBL_AW   = VEC_W + 2,
   parameter logic [3:0] FUNC_NUM = 4'd0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_VEC-1:0] irq_event,
   input  logic               msix_enable,
   input  logic               msix_func_mask,
   output logic [NUM_VEC-1:0] pba,
   msix_vector_ctrl_if.master bus
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_lo  [NUM_VEC];
   logic [31:0]        addr_hi  [NUM_VEC];
   logic [31:0]        msg_data [NUM_VEC];
   logic [NUM_VEC-1:0] mask_q;
   logic [NUM_VEC-1:0] pba_q;
   logic [NUM_VEC-1:0] elig;
   logic [NUM_VEC-1:0] clr;
   logic [VEC_W-1:0]   grant_q;
   logic [VEC_W-1:0]   ptr_q;
   logic [VEC_W-1:0]   tbl_vec;
   logic [1:0]         tbl_dw;
   logic [31:0]        rd_mux;
   logic [31:0]        rdata_q;
   logic               rvalid_q;
   logic [63:0]        irq_addr_q;
   logic [31:0]        irq_data_q;
   logic               grant_en;
   logic               load_en;
   logic               hs;

   // First set bit of req at or above start, wrapping around the vector count.
   function automatic logic [VEC_W-1:0] rr_pick(input logic [NUM_VEC-1:0] req,
                                                input logic [VEC_W-1:0]   start);
      logic [VEC_W-1:0] idx;
      logic             found;
      rr_pick = start;
      found   = 1'b0;
      for (int i = 0; i < NUM_VEC; i++) begin
         idx = start + VEC_W'(i);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   assign tbl_vec = bus.tbl_addr[TBL_AW-1:2];
   assign tbl_dw  = bus.tbl_addr[1:0];
   assign elig    = pba_q & ~mask_q & {NUM_VEC{msix_enable & ~msix_func_mask}};
   assign clr     = hs ? (NUM_VEC'(1) << grant_q) : '0;

   // Vector table storage; writes land in any FSM state, mask keeps bit0 only.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_VEC; i++) begin
            addr_lo[i]  <= '0;
            addr_hi[i]  <= '0;
            msg_data[i] <= '0;
         end
         mask_q <= '1;
      end else if (bus.tbl_we) begin
         case (tbl_dw)
            2'd0:    addr_lo[tbl_vec]  <= bus.tbl_wdata;
            2'd1:    addr_hi[tbl_vec]  <= bus.tbl_wdata;
            2'd2:    msg_data[tbl_vec] <= bus.tbl_wdata;
            default: mask_q[tbl_vec]   <= bus.tbl_wdata[0];
         endcase
      end
   end

   // Read mux over the pre-write table contents.
   always_comb begin
      rd_mux = '0;
      case (tbl_dw)
         2'd0:    rd_mux = addr_lo[tbl_vec];
         2'd1:    rd_mux = addr_hi[tbl_vec];
         2'd2:    rd_mux = msg_data[tbl_vec];
         default: rd_mux = {31'd0, mask_q[tbl_vec]};
      endcase
   end

   // Registered read port with a one-cycle valid pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= bus.tbl_re;
         if (bus.tbl_re) rdata_q <= rd_mux;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|elig) state_d = LOAD;
         LOAD:    state_d = SEND;
         SEND:    if (bus.irq_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM output decode: grant capture, payload load, handshake.
   always_comb begin
      grant_en = 1'b0;
      load_en  = 1'b0;
      hs       = 1'b0;
      case (state_q)
         IDLE:    grant_en = |elig;
         LOAD:    load_en  = 1'b1;
         SEND:    hs       = bus.irq_ready;
         default: ;
      endcase
   end

   // Grant index and round-robin pointer (advances past the served vector).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         if (grant_en) grant_q <= rr_pick(elig, ptr_q);
         if (hs)       ptr_q   <= grant_q + 1'b1;
      end
   end

   // Request payload, frozen from LOAD until the handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_addr_q <= '0;
         irq_data_q <= '0;
      end else if (load_en) begin
         irq_addr_q <= {addr_hi[grant_q], addr_lo[grant_q]};
         irq_data_q <= msg_data[grant_q];
      end
   end

   // Pending bits: a new event wins over the handshake clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pba_q <= '0;
      else     pba_q <= (pba_q & ~clr) | irq_event;
   end

   assign pba            = pba_q;
   assign bus.irq_valid  = (state_q == SEND);
   assign bus.irq_func   = FUNC_NUM;
   assign bus.irq_addr   = irq_addr_q;
   assign bus.irq_data   = irq_data_q;
   assign bus.tbl_rdata  = rdata_q;
   assign bus.tbl_rvalid = rvalid_q;

endmodule

// File: tb/tb_msix_vector_ctrl.sv
// Bench for msix_vector_ctrl: directed vectors with literal expectations
// plus a cycle-level model of pending bits, arbitration and payload.
module tb_msix_vector_ctrl;
   localparam int NV = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NV-1:0] irq_event = '0;
   logic          msix_enable = 1'b0;
   logic          msix_func_mask = 1'b0;
   logic [NV-1:0] pba;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [NV-1:0] m_pba, m_mask;
   logic [31:0]   m_lo [NV];
   logic [31:0]   m_hi [NV];
   logic [31:0]   m_dat[NV];
   int            m_ptr, m_g;
   bit            m_valid, m_load, m_rv;
   logic [63:0]   m_addr;
   logic [31:0]   m_data, m_rd;
   logic [31:0]   hs_log[$];

   always #5 clk = ~clk;

   msix_vector_ctrl_if #(.NUM_VEC(NV)) bus ();

   msix_vector_ctrl #(.NUM_VEC(NV), .FUNC_NUM(4'd0)) dut (
      .clk            (clk),
      .rst            (rst),
      .irq_event      (irq_event),
      .msix_enable    (msix_enable),
      .msix_func_mask (msix_func_mask),
      .pba            (pba),
      .bus            (bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   function automatic int rr(input logic [NV-1:0] e, input int p);
      for (int i = 0; i < NV; i++)
         if (e[(p + i) % NV]) return (p + i) % NV;
      return 0;
   endfunction

   // Model: compare on the falling edge, then advance to the state after the next rising edge.
   always @(negedge clk) begin
      logic [NV-1:0] e;
      bit            hs, nv, nl;
      int            v;
      if (rst) begin
         m_pba = '0; m_mask = '1; m_ptr = 0; m_g = 0;
         m_valid = 0; m_load = 0; m_rv = 0; m_addr = '0; m_data = '0; m_rd = '0;
         for (int i = 0; i < NV; i++) begin
            m_lo[i] = '0; m_hi[i] = '0; m_dat[i] = '0;
         end
         chk("m_rst_valid", 64'(bus.irq_valid), 64'd0);
         chk("m_rst_pba", 64'(pba), 64'd0);
      end else begin
         chk("m_valid", 64'(bus.irq_valid), 64'(m_valid));
         chk("m_pba", 64'(pba), 64'(m_pba));
         chk("m_rvalid", 64'(bus.tbl_rvalid), 64'(m_rv));
         if (m_rv) chk("m_rdata", 64'(bus.tbl_rdata), 64'(m_rd));
         if (m_valid) begin
            chk("m_addr", bus.irq_addr, m_addr);
            chk("m_data", 64'(bus.irq_data), 64'(m_data));
         end
         if (bus.irq_valid && bus.irq_ready) hs_log.push_back(bus.irq_data);

         e  = m_pba & ~m_mask & {NV{msix_enable & ~msix_func_mask}};
         hs = m_valid && bus.irq_ready;
         if (m_load) begin
            m_addr = {m_hi[m_g], m_lo[m_g]};
            m_data = m_dat[m_g];
         end
         if (hs) begin
            m_pba[m_g] = 1'b0;
            m_ptr = (m_g + 1) % NV;
         end
         m_pba = m_pba | irq_event;
         nv = m_valid ? !bus.irq_ready : m_load;
         nl = !m_valid && !m_load && (e != '0);
         if (nl) m_g = rr(e, m_ptr);
         m_valid = nv;
         m_load  = nl;

         v = int'(bus.tbl_addr[3:2]);
         m_rv = bus.tbl_re;
         if (bus.tbl_re) begin
            case (bus.tbl_addr[1:0])
               2'd0:    m_rd = m_lo[v];
               2'd1:    m_rd = m_hi[v];
               2'd2:    m_rd = m_dat[v];
               default: m_rd = {31'd0, m_mask[v]};
            endcase
         end
         if (bus.tbl_we) begin
            case (bus.tbl_addr[1:0])
               2'd0:    m_lo[v]   = bus.tbl_wdata;
               2'd1:    m_hi[v]   = bus.tbl_wdata;
               2'd2:    m_dat[v]  = bus.tbl_wdata;
               default: m_mask[v] = bus.tbl_wdata[0];
            endcase
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [1:0] v, input logic [1:0] dw, input logic [31:0] val);
      bus.tbl_we = 1'b1; bus.tbl_addr = {v, dw}; bus.tbl_wdata = val;
      tick();
      bus.tbl_we = 1'b0;
   endtask

   task automatic rd(input string name, input logic [1:0] v, input logic [1:0] dw,
                     input logic [31:0] exp);
      bus.tbl_re = 1'b1; bus.tbl_addr = {v, dw};
      tick();
      bus.tbl_re = 1'b0;
      chk({name, "_rvalid"}, 64'(bus.tbl_rvalid), 64'd1);
      chk(name, 64'(bus.tbl_rdata), 64'(exp));
   endtask

   task automatic pulse(input logic [NV-1:0] ev);
      irq_event = ev;
      tick();
      irq_event = '0;
   endtask

   task automatic wait_valid(input string name, input int max);
      int n = 0;
      while (!bus.irq_valid && n < max) begin
         tick();
         n++;
      end
      chk(name, 64'(bus.irq_valid), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1);
   end

   initial begin
      bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_wdata = '0;
      bus.tbl_re = 1'b0; bus.irq_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid", 64'(bus.irq_valid), 64'd0);
      chk("reset_pba", 64'(pba), 64'd0);
      chk("reset_rdata", 64'(bus.tbl_rdata), 64'd0);
      chk("reset_rvalid", 64'(bus.tbl_rvalid), 64'd0);
      chk("reset_func", 64'(bus.irq_func), 64'd0);
      chk("reset_addr", bus.irq_addr, 64'd0);
      rst = 1'b0;
      msix_enable = 1'b1;

      for (int v = 0; v < NV; v++) begin
         wr(2'(v), 2'd0, 32'hFEE0_0000);
         wr(2'(v), 2'd1, 32'(v));
         wr(2'(v), 2'd2, 32'h40 + 32'(v));
      end
      wr(2'd1, 2'd3, 32'h0);

      // single request on vector 1
      bus.irq_ready = 1'b1;
      pulse(4'b0010);
      chk("t1_pba", 64'(pba), 64'h2);
      chk("t1_valid_k0", 64'(bus.irq_valid), 64'd0);
      tick();
      chk("t1_valid_k1", 64'(bus.irq_valid), 64'd0);
      tick();
      chk("t1_valid_k2", 64'(bus.irq_valid), 64'd1);
      chk("t1_addr", bus.irq_addr, 64'h0000_0001_FEE0_0000);
      chk("t1_data", 64'(bus.irq_data), 64'h41);
      tick();
      chk("t1_single", 64'(bus.irq_valid), 64'd0);
      chk("t1_pba_clr", 64'(pba), 64'h0);

      // masked vector 2 stays pending until unmasked
      pulse(4'b0100);
      tick(); tick();
      chk("t2_pba", 64'(pba), 64'h4);
      chk("t2_masked", 64'(bus.irq_valid), 64'd0);
      wr(2'd2, 2'd3, 32'h0);
      chk("t2_u0", 64'(bus.irq_valid), 64'd0);
      tick();
      chk("t2_u1", 64'(bus.irq_valid), 64'd0);
      tick();
      chk("t2_u2", 64'(bus.irq_valid), 64'd1);
      chk("t2_data", 64'(bus.irq_data), 64'h42);
      tick();
      chk("t2_pba_clr", 64'(pba), 64'h0);

      // round robin: serve 3 first so the pointer wraps to 0
      wr(2'd0, 2'd3, 32'h0);
      wr(2'd3, 2'd3, 32'h0);
      pulse(4'b1000);
      repeat (6) tick();
      hs_log.delete();
      pulse(4'b1111);
      repeat (16) tick();
      chk("t3_count", 64'(hs_log.size()), 64'd4);
      if (hs_log.size() == 4) begin
         chk("t3_g0", 64'(hs_log[0]), 64'h40);
         chk("t3_g1", 64'(hs_log[1]), 64'h41);
         chk("t3_g2", 64'(hs_log[2]), 64'h42);
         chk("t3_g3", 64'(hs_log[3]), 64'h43);
      end
      hs_log.delete();
      pulse(4'b1001);
      repeat (10) tick();
      chk("t3b_count", 64'(hs_log.size()), 64'd2);
      if (hs_log.size() == 2) begin
         chk("t3b_g0", 64'(hs_log[0]), 64'h40);
         chk("t3b_g1", 64'(hs_log[1]), 64'h43);
      end

      // stalled request ignores table and function-mask changes
      bus.irq_ready = 1'b0;
      pulse(4'b0001);
      wait_valid("t4_wait", 8);
      wr(2'd0, 2'd2, 32'h99);
      msix_func_mask = 1'b1;
      irq_event = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tick();
         irq_event = '0;
         chk("t4_hold_valid", 64'(bus.irq_valid), 64'd1);
         chk("t4_hold_data", 64'(bus.irq_data), 64'h40);
         chk("t4_hold_addr", bus.irq_addr, 64'h0000_0000_FEE0_0000);
      end
      bus.irq_ready = 1'b1;
      tick();
      chk("t4_done", 64'(bus.irq_valid), 64'd0);
      repeat (5) tick();
      chk("t4_fmask_idle", 64'(bus.irq_valid), 64'd0);
      chk("t4_fmask_pba", 64'(pba), 64'h2);
      msix_func_mask = 1'b0;
      wait_valid("t4_resume", 8);
      chk("t4_resume_data", 64'(bus.irq_data), 64'h41);
      tick();
      chk("t4_pba_clr", 64'(pba), 64'h0);

      // event on the handshake edge keeps the vector pending
      pulse(4'b0001);
      wait_valid("t5_wait", 8);
      irq_event = 4'b0001;
      tick();
      irq_event = '0;
      chk("t5_pba_kept", 64'(pba), 64'h1);
      chk("t5_valid_low", 64'(bus.irq_valid), 64'd0);
      wait_valid("t5_second", 8);
      chk("t5_second_data", 64'(bus.irq_data), 64'h99);
      tick();
      chk("t5_pba_clr", 64'(pba), 64'h0);

      // asynchronous reset during SEND
      bus.irq_ready = 1'b0;
      pulse(4'b0100);
      wait_valid("t6_wait", 8);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", 64'(bus.irq_valid), 64'd0);
      chk("t6_rst_pba", 64'(pba), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.irq_ready = 1'b1;
      rd("t6_mask1", 2'd1, 2'd3, 32'h1);
      rd("t6_data2", 2'd2, 2'd2, 32'h0);
      wr(2'd1, 2'd3, 32'hFFFF_FFFF);
      rd("t6_mask_bits", 2'd1, 2'd3, 32'h1);
      wr(2'd1, 2'd3, 32'hFFFF_FFFE);
      rd("t6_mask_clr", 2'd1, 2'd3, 32'h0);

      // read and write to the same dword in one cycle returns old data
      bus.tbl_we = 1'b1; bus.tbl_re = 1'b1;
      bus.tbl_addr = {2'd0, 2'd2}; bus.tbl_wdata = 32'h55;
      tick();
      bus.tbl_we = 1'b0; bus.tbl_re = 1'b0;
      chk("t7_old_data", 64'(bus.tbl_rdata), 64'h0);
      rd("t7_new_data", 2'd0, 2'd2, 32'h55);

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/msix_vector_ctrl.md
Name: msix_vector_ctrl

Overview:
- Interrupt source for the irq_proc request channel.
- Holds an MSI-X style vector table: per-vector address, data and mask. Holds the pending-bit array.
- Collects per-channel event pulses from the DMA engines, arbitrates round-robin among pending, unmasked vectors, and issues one request at a time on the irq_valid/irq_ready handshake that irq_proc consumes.
- The table is written and read by the completer-side BAR register decoder.

Parameters:
NUM_VEC, 4, number of interrupt vectors (power of two, 2..32)
VEC_W, $clog2(NUM_VEC), vector index width
TBL_AW, VEC_W+2, table dword address width
FUNC_NUM, 4'd0, value driven on irq_func

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
irq_event  in  NUM_VEC  per-vector event pulse; multi-cycle high is treated as repeated events
msix_enable  in  1  MSI-X enable from config space
msix_func_mask  in  1  MSI-X function mask from config space
tbl_we  in  1  table write strobe
tbl_addr  in  TBL_AW  {vector, dword}; dword 0=addr[31:0], 1=addr[63:32], 2=data, 3=vector control (bit0=mask)
tbl_wdata  in  32  table write data
tbl_re  in  1  table read strobe
tbl_rdata  out  32  table read data, valid one cycle after tbl_re
tbl_rvalid  out  1  read data valid pulse
pba  out  NUM_VEC  pending-bit array
irq_valid  out  1  request valid
irq_func  out  4  function number (= FUNC_NUM)
irq_addr  out  64  message address
irq_data  out  32  message data
irq_ready  in  1  accept from irq_proc

Behaviour:
- Reset values: all address/data entries 0; all mask bits 1; pba 0; irq_valid 0; irq_addr 0; irq_data 0; tbl_rdata 0; tbl_rvalid 0; round-robin pointer 0; state IDLE.
- Pending bits:
  - A sampled irq_event[i] sets pba[i] on the next edge, regardless of the mask.
  - pba[i] clears on the handshake edge (irq_valid & irq_ready) for granted vector i.
  - If irq_event[i] is high on that same edge, pba[i] stays 1. Set wins over clear.
- Eligible vector: pba[i] & ~mask[i] & msix_enable & ~msix_func_mask.
- FSM states:
  - IDLE: if any vector is eligible, register grant index g = first eligible vector searching from pointer upward with wrap; go to LOAD.
  - LOAD: latch irq_addr/irq_data from table[g]; set irq_valid=1; go to SEND.
  - SEND: hold irq_valid and all payload stable until irq_ready. On the handshake edge: clear irq_valid, clear pba[g], set pointer = g+1 mod NUM_VEC, go to IDLE.
- Latency:
  - Event sampled at edge k; pba high after edge k; irq_valid high after edge k+2.
  - Minimum spacing between consecutive requests: 2 idle cycles (handshake -> IDLE -> LOAD).
- No retraction in SEND. Changes to the mask, msix_enable, msix_func_mask or the table entry during SEND have no effect on the in-flight request; it completes with the latched payload.
- Mask set while a vector is pending: the vector stays pending and is not granted. Clearing the mask makes it eligible next cycle.
- Table write to vector control affects only bit0. Bits 31:1 read back 0.
- Read port:
  - tbl_rdata is registered from the table on a tbl_re edge, with tbl_rvalid pulsing one cycle.
  - A simultaneous write and read to the same dword returns old data.
- Table writes are accepted in any state.
- Reset asserted mid-SEND: irq_valid drops immediately (asynchronously); pba clears; all events are lost.
- irq_func is a constant FUNC_NUM, also during reset.

Test Plan:
- Program vector 1: addr=0x0000_0001_FEE0_0000, data=0x0000_0041, mask=0. Pulse irq_event[1] one cycle -> irq_valid rises 2 edges later with irq_addr=0x0000_0001_FEE0_0000, irq_data=0x41. With irq_ready=1 it is single-cycle; afterwards pba=0.
- Vector 2 left masked after reset; pulse event 2 -> pba=4'b0100, no irq_valid. Clear mask -> request for vector 2 appears 2 cycles later.
- Unmask all, pulse events 0..3 simultaneously, irq_ready always 1 -> grants in order 0,1,2,3. Then pulse 0 and 3 with pointer=0 -> 0 then 3.
- irq_ready held 0 for 10 cycles; during SEND rewrite the vector 0 data to 0x99 and set msix_func_mask=1 -> irq_valid and the original payload remain stable; handshake completes. No further grants while the function mask is set.
- irq_event[0] high on the same edge as the vector 0 handshake -> pba[0]=1 afterwards; a second request for vector 0 follows.
- Assert rst while irq_valid=1 -> irq_valid=0 and pba=0 immediately. After release, mask bits read back 1 via tbl_re (tbl_rdata=0x1 at dword 3).
